// File: rtl/fml_vga_arb.sv
// Two-master FML arbiter: VGA fetch (port 0, priority) and CPU bridge (port 1),
// with a starvation limit on port 0 and write-data steering for the 8-beat data phase.
//
// state | meaning
// IDLE  | no grant; arbitrates when the data phase counter is zero
// GNT0  | port 0 drives the slave request until s_ack
// GNT1  | port 1 drives the slave request until s_ack
module fml_vga_arb #(
  parameter int fml_depth   = 20,
  parameter int vga_max_run = 4
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic [fml_depth-1:0] m0_adr,
  input  logic                 m0_stb,
  input  logic                 m0_we,
  output logic                 m0_ack,
  input  logic [1:0]           m0_sel,
  input  logic [15:0]          m0_di,
  output logic [15:0]          m0_do,

  input  logic [fml_depth-1:0] m1_adr,
  input  logic                 m1_stb,
  input  logic                 m1_we,
  output logic                 m1_ack,
  input  logic [1:0]           m1_sel,
  input  logic [15:0]          m1_di,
  output logic [15:0]          m1_do,

  output logic [fml_depth-1:0] s_adr,
  output logic                 s_stb,
  output logic                 s_we,
  input  logic                 s_ack,
  output logic [1:0]           s_sel,
  output logic [15:0]          s_do,
  input  logic [15:0]          s_di
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  localparam logic [3:0] MAX_RUN = 4'(vga_max_run);

  state_t     state;
  logic [3:0] cnt;
  logic [3:0] run;
  logic       owner;

  logic arb, pick0, pick1, ack0, ack1;

  always_comb begin
    arb   = (state == IDLE) && (cnt == 4'd0);
    pick0 = arb && m0_stb && (!m1_stb || (run < MAX_RUN));
    pick1 = arb && !pick0 && m1_stb;
    ack0  = (state == GNT0) && s_ack;
    ack1  = (state == GNT1) && s_ack;
  end

  always_comb begin
    s_stb = 1'b0;
    s_adr = '0;
    s_we  = 1'b0;
    case (state)
      GNT0: begin
        s_stb = m0_stb;
        s_adr = m0_adr;
        s_we  = m0_we;
      end
      GNT1: begin
        s_stb = m1_stb;
        s_adr = m1_adr;
        s_we  = m1_we;
      end
      default: ;
    endcase
  end

  assign m0_ack = ack0;
  assign m1_ack = ack1;
  assign m0_do  = s_di;
  assign m1_do  = s_di;

  // Write beats follow whichever port owned the last acknowledged burst.
  always_comb begin
    s_do  = 16'h0000;
    s_sel = 2'b00;
    if (cnt != 4'd0) begin
      s_do  = owner ? m1_di  : m0_di;
      s_sel = owner ? m1_sel : m0_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      run   <= 4'd0;
      owner <= 1'b0;
    end else begin
      if (cnt != 4'd0)
        cnt <= cnt - 4'd1;

      case (state)
        IDLE: begin
          if (pick0)      state <= GNT0;
          else if (pick1) state <= GNT1;
        end
        GNT0: begin
          if (s_ack) begin
            owner <= 1'b0;
            cnt   <= 4'd8;
            state <= IDLE;
          end else if (!m0_stb) begin
            state <= IDLE;
          end
        end
        GNT1: begin
          if (s_ack) begin
            owner <= 1'b1;
            cnt   <= 4'd8;
            state <= IDLE;
          end else if (!m1_stb) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // run only matters while port 1 is waiting on port 0's bursts
      if (!m1_stb || ack1)
        run <= 4'd0;
      else if (ack0 && (run != 4'd15))
        run <= run + 4'd1;
    end
  end

endmodule

// File: tb/tb_fml_vga_arb.sv
// Directed bench for fml_vga_arb: stimulus pushes expected acks into a scoreboard,
// a negedge monitor pops and compares them; data-phase routing is checked inline.
module tb_fml_vga_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] m0_adr = '0, m1_adr = '0;
  logic        m0_stb = 1'b0, m1_stb = 1'b0;
  logic        m0_we = 1'b0, m1_we = 1'b0;
  logic        m0_ack, m1_ack;
  logic [1:0]  m0_sel = 2'b00, m1_sel = 2'b00;
  logic [15:0] m0_di = '0, m1_di = '0;
  logic [15:0] m0_do, m1_do;
  logic [19:0] s_adr;
  logic        s_stb, s_we;
  logic        s_ack = 1'b0;
  logic [1:0]  s_sel;
  logic [15:0] s_do;
  logic [15:0] s_di = 16'h1234;

  fml_vga_arb #(.fml_depth(20), .vga_max_run(4)) dut (
    .clk(clk), .rst(rst),
    .m0_adr(m0_adr), .m0_stb(m0_stb), .m0_we(m0_we), .m0_ack(m0_ack),
    .m0_sel(m0_sel), .m0_di(m0_di), .m0_do(m0_do),
    .m1_adr(m1_adr), .m1_stb(m1_stb), .m1_we(m1_we), .m1_ack(m1_ack),
    .m1_sel(m1_sel), .m1_di(m1_di), .m1_do(m1_do),
    .s_adr(s_adr), .s_stb(s_stb), .s_we(s_we), .s_ack(s_ack),
    .s_sel(s_sel), .s_do(s_do), .s_di(s_di)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    bit          port;
    logic [19:0] adr;
    bit          we;
  } sb_t;

  sb_t sb[$];
  int  cyc = 0;
  int  n_tests = 0;
  int  n_fail = 0;
  int  ack_lat = 0;
  bit  force_ack = 1'b0;
  int  age = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic tickn(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic expect_ack(input int c, input bit p, input logic [19:0] a, input bit w);
    sb_t e;
    e.cyc = c; e.port = p; e.adr = a; e.we = w;
    sb.push_back(e);
  endtask

  // Slave: acks after ack_lat cycles of continuous s_stb
  always @(posedge clk) begin
    #2;
    if (s_stb) begin
      s_ack = (age >= ack_lat) || force_ack;
      age++;
    end else begin
      age = 0;
      s_ack = force_ack;
    end
  end

  always @(negedge clk) begin
    if (m0_ack || m1_ack) begin
      if (m0_ack && m1_ack) begin
        n_tests++; n_fail++;
        $display("FAIL dual_ack at cycle %0d: both ports acked, expected one", cyc);
      end
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_ack at cycle %0d: m0_ack=%0b m1_ack=%0b, expected none",
                 cyc, m0_ack, m1_ack);
      end else begin
        sb_t e;
        e = sb.pop_front();
        n_tests++;
        if (cyc != e.cyc || m1_ack != e.port || s_adr !== e.adr || s_we != e.we) begin
          n_fail++;
          $display("FAIL ack_scoreboard: got cyc=%0d port=%0d adr=%h we=%0b, expected cyc=%0d port=%0d adr=%h we=%0b",
                   cyc, m1_ack, s_adr, s_we, e.cyc, e.port, e.adr, e.we);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    // reset state
    tickn(2);
    @(negedge clk);
    chk("rst_s_stb", s_stb, 0);
    chk("rst_s_adr", s_adr, 0);
    chk("rst_s_we", s_we, 0);
    chk("rst_s_sel", s_sel, 0);
    chk("rst_s_do", s_do, 0);
    chk("rst_m0_ack", m0_ack, 0);
    chk("rst_m1_ack", m1_ack, 0);
    chk("rst_m0_do", m0_do, 16'h1234);
    chk("rst_m1_do", m1_do, 16'h1234);
    tick();
    cyc = 0;
    rst = 1'b0;

    // single VGA read, slave acks at cycle 3
    m0_stb = 1'b1; m0_adr = 20'h01230; ack_lat = 2;
    expect_ack(3, 0, 20'h01230, 0);
    @(negedge clk) chk("vga_stb_c0", s_stb, 0);
    tick();
    @(negedge clk);
    chk("vga_stb_c1", s_stb, 1);
    chk("vga_adr_c1", s_adr, 20'h01230);
    tickn(3);
    ack_lat = 0;
    expect_ack(13, 0, 20'h01230, 0);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk) chk("vga_gap_stb", s_stb, 0);
      tick();
    end
    @(negedge clk) chk("vga_regrant_c13", s_stb, 1);
    tick();
    m0_stb = 1'b0;
    tickn(8);

    // CPU write routing
    m1_stb = 1'b1; m1_we = 1'b1; m1_adr = 20'h00400;
    m0_di = 16'h5555; m0_sel = 2'b11;
    t = cyc + 1;
    expect_ack(t, 1, 20'h00400, 1);
    tick();
    for (int k = 1; k <= 8; k++) begin
      tick();
      m1_stb = 1'b0; m1_we = 1'b0;
      m1_di = 16'hA000 + 16'(k); m1_sel = 2'b01;
      @(negedge clk);
      chk("wr_s_do", s_do, 16'hA000 + 16'(k));
      chk("wr_s_sel", s_sel, 2'b01);
    end
    tick();
    m1_di = 16'hA009;
    @(negedge clk);
    chk("wr_end_s_do", s_do, 0);
    chk("wr_end_s_sel", s_sel, 0);
    s_di = 16'hCAFE;
    #1;
    chk("rd_bcast_m0", m0_do, 16'hCAFE);
    chk("rd_bcast_m1", m1_do, 16'hCAFE);

    // starvation limit: both held continuously
    tick();
    m0_stb = 1'b1; m0_adr = 20'h00100;
    m1_stb = 1'b1; m1_adr = 20'h00200;
    t = cyc;
    for (int i = 0; i < 10; i++) begin
      if (i == 4 || i == 9) expect_ack(t + 1 + 10 * i, 1, 20'h00200, 0);
      else                  expect_ack(t + 1 + 10 * i, 0, 20'h00100, 0);
    end
    tickn(92);
    m0_stb = 1'b0; m1_stb = 1'b0;
    tickn(9);

    // port 1 alone
    m1_stb = 1'b1; m1_adr = 20'h00333;
    expect_ack(cyc + 1, 1, 20'h00333, 0);
    tick();
    @(negedge clk) chk("p1_alone_stb", s_stb, 1);
    tick();
    m1_stb = 1'b0;
    tickn(8);

    // aborted port-1 request, pending port 0 granted afterwards
    m1_stb = 1'b1; m1_adr = 20'h00777; ack_lat = 100;
    tick();
    @(negedge clk);
    chk("abort_granted_stb", s_stb, 1);
    chk("abort_granted_adr", s_adr, 20'h00777);
    tick();
    m1_stb = 1'b0; m0_stb = 1'b1; m0_adr = 20'h00888; ack_lat = 0;
    expect_ack(cyc + 2, 0, 20'h00888, 0);
    @(negedge clk) chk("abort_drop_stb", s_stb, 0);
    tick();
    @(negedge clk) chk("abort_idle_stb", s_stb, 0);
    tick();
    @(negedge clk);
    chk("abort_m0_stb", s_stb, 1);
    chk("abort_m0_adr", s_adr, 20'h00888);
    tick();
    m0_stb = 1'b0;
    tickn(8);

    // reset mid data phase
    m1_stb = 1'b1; m1_we = 1'b1; m1_adr = 20'h00480;
    m1_sel = 2'b10; m1_di = 16'hBEEF;
    expect_ack(cyc + 1, 1, 20'h00480, 1);
    tick();
    tick();
    m1_stb = 1'b0; m1_we = 1'b0;
    tickn(3);
    @(negedge clk);
    chk("rstmid_pre_sel", s_sel, 2'b10);
    chk("rstmid_pre_do", s_do, 16'hBEEF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m0_stb = 1'b1; m0_adr = 20'h00999;
    expect_ack(cyc + 1, 0, 20'h00999, 0);
    @(negedge clk);
    chk("rstmid_sel", s_sel, 0);
    chk("rstmid_do", s_do, 0);
    chk("rstmid_stb", s_stb, 0);
    tick();
    tick();
    m0_stb = 1'b0;
    tickn(8);

    // spurious slave ack in IDLE
    force_ack = 1'b1;
    @(negedge clk);
    chk("spur_m0_ack", m0_ack, 0);
    chk("spur_m1_ack", m1_ack, 0);
    tick();
    force_ack = 1'b0;
    m0_stb = 1'b1; m0_adr = 20'h00AAA;
    expect_ack(cyc + 1, 0, 20'h00AAA, 0);
    tick();
    tick();
    m0_stb = 1'b0;
    tickn(10);

    chk("sb_leftover", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
